scsu_ahb_mem_slave: RTL and testbench

- Single-port AHB-lite slave memory model, 16-bit data.
- Serves the scsu AHB master port: scsu master outputs connect to this block; this block's responses feed the scsu master inputs.
- Provides byte/halfword read-write storage with configurable wait states and an ERROR response for illegal or out-of-range accesses.
- Used as the system-memory endpoint in scsu subsystem simulation.

---
 rtl/scsu_ahb_mem_slave.sv | 155 +++++++++++++++
 tb/tb_scsu_ahb_mem_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scsu_ahb_mem_slave.sv
// AHB-lite 16-bit memory slave for the scsu master port: wait states, ERROR on illegal access.
// Define SCSU_AHB_MEM_CLR_EN to clear the memory array whenever rst is asserted.
module scsu_ahb_mem_slave #(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scsu_m_ahb_mhtrans,
  input  logic [1:0]  scsu_m_ahb_mhsize,
  input  logic        scsu_m_ahb_mhwrite,
  input  logic [15:0] scsu_m_ahb_mhaddr,
  input  logic [15:0] scsu_m_ahb_mhwdata,
  output logic [15:0] ahb_scsu_m_shrdata,
  output logic        ahb_scsu_m_shready,
  output logic [1:0]  ahb_scsu_m_shresp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [MEM_AW:0]   addr_r;
  logic              byte_r;
  logic              write_r;
  logic [15:0]       mem_r [0:(2**MEM_AW)-1];
  logic              accept_s;
  logic              illegal_s;
  logic              wr_en_s;
  logic [MEM_AW-1:0] idx_s;

  // Little-endian lane merge: byte writes touch only the lane selected by addr[0].
  function automatic logic [15:0] merge_f(input logic [15:0] old_d, input logic [15:0] wr_d,
                                          input logic is_byte, input logic hi_lane);
    if (!is_byte)
      merge_f = wr_d;
    else if (hi_lane)
      merge_f = {wr_d[15:8], old_d[7:0]};
    else
      merge_f = {old_d[15:8], wr_d[7:0]};
  endfunction

  assign accept_s  = ahb_scsu_m_shready &
                     ((scsu_m_ahb_mhtrans == 2'b10) || (scsu_m_ahb_mhtrans == 2'b11));
  assign illegal_s = scsu_m_ahb_mhsize[1]
                   | (scsu_m_ahb_mhsize[0] & scsu_m_ahb_mhaddr[0])
                   | ((scsu_m_ahb_mhaddr >> (MEM_AW + 1)) != 16'd0);
  assign idx_s     = addr_r[MEM_AW:1];
  assign wr_en_s   = (state_r == ST_LAST) & write_r;

  // Data-phase state register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Capture the address-phase attributes for the following data phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r  <= {(MEM_AW+1){1'b0}};
      byte_r  <= 1'b0;
      write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= scsu_m_ahb_mhaddr[MEM_AW:0];
      byte_r  <= (scsu_m_ahb_mhsize == 2'b00);
      write_r <= scsu_m_ahb_mhwrite;
    end
  end

  // Next-state: a new transfer may only start from a cycle where shready is high.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_LAST;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (illegal_s) begin
          state_nxt_s = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_nxt_s = ST_LAST;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = 4'(WAIT_STATES);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Response decode; read data follows the array so a just-written word is visible.
  always_comb begin
    ahb_scsu_m_shready = 1'b1;
    ahb_scsu_m_shresp  = 2'b00;
    ahb_scsu_m_shrdata = 16'h0000;
    case (state_r)
      ST_WAIT, ST_LAST: begin
        ahb_scsu_m_shready = (state_r == ST_LAST);
        if (!write_r)
          ahb_scsu_m_shrdata = mem_r[idx_s];
        else
          ahb_scsu_m_shrdata = 16'h0000;
      end
      ST_ERR1: begin
        ahb_scsu_m_shready = 1'b0;
        ahb_scsu_m_shresp  = 2'b01;
      end
      ST_ERR2: ahb_scsu_m_shresp = 2'b01;
      ST_IDLE: ahb_scsu_m_shready = 1'b1;
      default: ahb_scsu_m_shready = 1'b1;
    endcase
  end

`ifdef SCSU_AHB_MEM_CLR_EN
  // Storage array, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**MEM_AW; i++)
        mem_r[i] <= 16'h0000;
    end else if (wr_en_s) begin
      mem_r[idx_s] <= merge_f(mem_r[idx_s], scsu_m_ahb_mhwdata, byte_r, addr_r[0]);
    end
  end
`else
  // Storage array, retained across reset.
  always_ff @(posedge clk) begin
    if (wr_en_s)
      mem_r[idx_s] <= merge_f(mem_r[idx_s], scsu_m_ahb_mhwdata, byte_r, addr_r[0]);
  end
`endif

endmodule

// File: tb/tb_scsu_ahb_mem_slave.sv
// Self-checking bench for scsu_ahb_mem_slave: zero-wait and two-wait instances, scoreboard of
// expected completions checked as each data phase ends.
module tb_scsu_ahb_mem_slave;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } stim_t;

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] rdata;
    int          waits;
  } exp_t;

  localparam int WS [2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  htrans [2];
  logic [1:0]  hsize  [2];
  logic        hwrite [2];
  logic [15:0] haddr  [2];
  logic [15:0] hwdata [2];
  logic [15:0] rdata  [2];
  logic        ready  [2];
  logic [1:0]  resp   [2];

  stim_t stim_q [$];
  exp_t  exp_q  [$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] rst_exp;

  always #5 clk = ~clk;

  scsu_ahb_mem_slave #(.MEM_AW(12), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .scsu_m_ahb_mhtrans(htrans[0]), .scsu_m_ahb_mhsize(hsize[0]),
    .scsu_m_ahb_mhwrite(hwrite[0]), .scsu_m_ahb_mhaddr(haddr[0]),
    .scsu_m_ahb_mhwdata(hwdata[0]),
    .ahb_scsu_m_shrdata(rdata[0]), .ahb_scsu_m_shready(ready[0]),
    .ahb_scsu_m_shresp(resp[0])
  );

  scsu_ahb_mem_slave #(.MEM_AW(12), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst),
    .scsu_m_ahb_mhtrans(htrans[1]), .scsu_m_ahb_mhsize(hsize[1]),
    .scsu_m_ahb_mhwrite(hwrite[1]), .scsu_m_ahb_mhaddr(haddr[1]),
    .scsu_m_ahb_mhwdata(hwdata[1]),
    .ahb_scsu_m_shrdata(rdata[1]), .ahb_scsu_m_shready(ready[1]),
    .ahb_scsu_m_shresp(resp[1])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Queue one transfer and the completion it must produce on instance sel.
  task automatic add(input int sel, input logic wr, input logic [1:0] sz, input logic [15:0] a,
                     input logic [15:0] wd, input logic err, input logic [15:0] rd);
    stim_t s;
    exp_t  e;
    s.wr = wr; s.size = sz; s.addr = a; s.wdata = wd;
    e.resp  = err ? 2'b01 : 2'b00;
    e.rdata = (err || wr) ? 16'h0000 : rd;
    e.waits = err ? 1 : WS[sel];
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Drive queued transfers back-to-back; entered and left #1 after a rising edge.
  task automatic run(input int sel);
    stim_t cur;
    exp_t  e;
    bit    dp = 1'b0;
    bit    drove;
    int    waits = 0;
    int    budget = 0;
    while ((stim_q.size() > 0 || dp) && budget < 100) begin
      if (stim_q.size() > 0) begin
        htrans[sel] = 2'b10;
        hsize[sel]  = stim_q[0].size;
        hwrite[sel] = stim_q[0].wr;
        haddr[sel]  = stim_q[0].addr;
        drove = 1'b1;
      end else begin
        htrans[sel] = 2'b00;
        drove = 1'b0;
      end
      hwdata[sel] = (dp && cur.wr) ? cur.wdata : 16'h0000;
      @(negedge clk);
      if (dp) begin
        if (ready[sel] === 1'b1) begin
          e = exp_q.pop_front();
          chk($sformatf("u%0d_resp_%h", sel, cur.addr), {14'd0, resp[sel]}, {14'd0, e.resp});
          chk($sformatf("u%0d_rdata_%h", sel, cur.addr), rdata[sel], e.rdata);
          chk($sformatf("u%0d_waits_%h", sel, cur.addr), 16'(waits), 16'(e.waits));
          dp = 1'b0;
        end else begin
          waits++;
          if (exp_q.size() > 0)
            chk($sformatf("u%0d_wait_resp_%h", sel, cur.addr), {14'd0, resp[sel]},
                {14'd0, exp_q[0].resp});
        end
      end
      if (drove && ready[sel] === 1'b1) begin
        cur = stim_q.pop_front();
        dp = 1'b1;
        waits = 0;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    chk($sformatf("u%0d_run_timeout", sel), 16'(budget >= 100), 16'd0);
    stim_q.delete();
    exp_q.delete();
    htrans[sel] = 2'b00;
    hwdata[sel] = 16'h0000;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      htrans[s] = 2'b00; hsize[s] = 2'b01; hwrite[s] = 1'b0;
      haddr[s] = 16'h0000; hwdata[s] = 16'h0000;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("u%0d_rst_ready", s), {15'd0, ready[s]}, 16'd1);
      chk($sformatf("u%0d_rst_resp", s), {14'd0, resp[s]}, 16'd0);
      chk($sformatf("u%0d_rst_rdata", s), rdata[s], 16'h0000);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait instance: halfword, byte lanes, errors, back-to-back forwarding.
    add(0, 1'b1, 2'b01, 16'h0010, 16'hA5C3, 1'b0, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0010, 16'h0000, 1'b0, 16'hA5C3);
    run(0);
    add(0, 1'b1, 2'b00, 16'h0011, 16'h7700, 1'b0, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0010, 16'h0000, 1'b0, 16'h77C3);
    add(0, 1'b1, 2'b00, 16'h0010, 16'h0011, 1'b0, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0010, 16'h0000, 1'b0, 16'h7711);
    run(0);
    add(0, 1'b0, 2'b01, 16'h0003, 16'h0000, 1'b1, 16'h0000);
    add(0, 1'b1, 2'b01, 16'h0000, 16'h1111, 1'b0, 16'h0000);
    add(0, 1'b1, 2'b01, 16'h2000, 16'hDEAD, 1'b1, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0000, 16'h0000, 1'b0, 16'h1111);
    add(0, 1'b0, 2'b10, 16'h0010, 16'h0000, 1'b1, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0010, 16'h0000, 1'b0, 16'h7711);
    run(0);
    add(0, 1'b1, 2'b01, 16'h0020, 16'h1234, 1'b0, 16'h0000);
    add(0, 1'b0, 2'b01, 16'h0020, 16'h0000, 1'b0, 16'h1234);
    add(0, 1'b1, 2'b01, 16'h0040, 16'hFFFF, 1'b0, 16'h0000);
    run(0);

    // Two-wait instance.
    add(1, 1'b1, 2'b01, 16'h0010, 16'h7711, 1'b0, 16'h0000);
    run(1);
    add(1, 1'b0, 2'b01, 16'h0010, 16'h0000, 1'b0, 16'h7711);
    run(1);
    add(1, 1'b1, 2'b01, 16'h0020, 16'h1234, 1'b0, 16'h0000);
    add(1, 1'b0, 2'b01, 16'h0020, 16'h0000, 1'b0, 16'h1234);
    add(1, 1'b0, 2'b01, 16'h0003, 16'h0000, 1'b1, 16'h0000);
    run(1);

    // Reset in the data phase of a write to 0x0040 aborts it.
    htrans[0] = 2'b10; hsize[0] = 2'b01; hwrite[0] = 1'b1; haddr[0] = 16'h0040;
    @(posedge clk);
    #1;
    htrans[0] = 2'b00;
    hwdata[0] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {15'd0, ready[0]}, 16'd1);
    chk("mid_rst_resp", {14'd0, resp[0]}, 16'd0);
    chk("mid_rst_rdata", rdata[0], 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
`ifdef SCSU_AHB_MEM_CLR_EN
    rst_exp = 16'h0000;
`else
    rst_exp = 16'hFFFF;
`endif
    add(0, 1'b0, 2'b01, 16'h0040, 16'h0000, 1'b0, rst_exp);
    run(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
